// File: rtl/msub_pkg.sv
// Shared definitions for the multi-precision subtract sequencer:
// state encodings, the FSM state type and a small sizing helper.
package msub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Limb index width: enough bits to count 0..k-1, never narrower than one bit.
    function automatic int idxWidth(input int k);
        int w;
        w = $clog2(k);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/msub_seq_if.sv
// Request/result bundle of the subtract sequencer. The master issues the
// operation request; the slave (the sequencer) returns status and result.
interface msub_seq_if #(
    parameter int N = 4,
    parameter int K = 4
);
    localparam int W = N * K;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );

endinterface

// File: rtl/msub_seq_limb_sub.sv
// One N-bit limb subtractor with borrow in and borrow out. Purely
// combinational; the sequencer time-multiplexes a single instance.
module limb_sub #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bi,
    output logic [N-1:0] d,
    output logic         bo
);

    logic [N:0] full;

    // Subtract in N+1 bits so the top bit falls out as the borrow.
    always_comb begin
        full = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
    end

    assign d  = full[N-1:0];
    assign bo = full[N];

endmodule

// File: rtl/msub_seq.sv
// Multi-precision subtract sequencer: computes a - b - bin on K limbs of N
// bits, one limb per cycle from the least significant limb upward, chaining
// the borrow through a register. All outputs are registered.
module msub_seq
    import msub_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 4
) (
    input logic      clk,
    input logic      rst,
    msub_seq_if.slave bus
);

    localparam int W  = N * K;
    localparam int IW = idxWidth(K);
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          borrow_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  diff_q;
    logic          bout_q;
    logic          busy_q;
    logic          done_q;

    logic [N-1:0]  x_d;
    logic [N-1:0]  y_d;
    logic [N-1:0]  limb_d;
    logic          borrow_d;

    assign x_d = a_q[idx_q*N +: N];
    assign y_d = b_q[idx_q*N +: N];

    limb_sub #(.N(N)) u_limb (
        .x  (x_d),
        .y  (y_d),
        .bi (borrow_q),
        .d  (limb_d),
        .bo (borrow_d)
    );

    // Sequencer FSM: accepts a request when not busy, walks the limbs, and
    // pulses done once the top limb and the final borrow are stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        idx_q    <= '0;
                        diff_q   <= '0;
                        bout_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    diff_q[idx_q*N +: N] <= limb_d;
                    borrow_q             <= borrow_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        bout_q  <= borrow_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_msub_seq.sv
// Directed plus randomized bench for msub_seq (N=4, K=4). Expected results
// come from plain integer subtraction on the whole operands.
module tb_msub_seq;

    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    msub_seq_if #(.N(N), .K(K)) busIf ();

    msub_seq #(.N(N), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    always #5 clk = ~clk;

    // Whole-operand reference: {borrow, difference} of a - b - bin.
    function automatic logic [W:0] refSub(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic binv);
        int unsigned ai;
        int unsigned bi;
        logic [31:0] r;
        ai = int'(av);
        bi = int'(bv) + int'(binv);
        r  = ai - bi;
        return {(ai < bi), r[W-1:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; start is seen by the next rising edge and the
    // task returns at the falling edge right after acceptance.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic binv);
        busIf.a     = av;
        busIf.b     = bv;
        busIf.bin   = binv;
        busIf.start = 1'b1;
        @(negedge clk);
        busIf.start = 1'b0;
    endtask

    // Bounded wait for done; optionally scrambles operand ports meanwhile.
    task automatic waitDone(input bit scramble, output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (busIf.done !== 1'b1 && cycles < 20) begin
            if (busIf.busy === 1'b1) busyCycles++;
            if (scramble) begin
                busIf.a   = W'($urandom);
                busIf.b   = W'($urandom);
                busIf.bin = 1'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic binv, input bit scramble);
        int c;
        int bc;
        logic [W:0] exp;
        exp = refSub(av, bv, binv);
        applyStimulus(av, bv, binv);
        waitDone(scramble, c, bc);
        checkOutput({tag, ".latency"}, W'(c), W'(K));
        checkOutput({tag, ".busyCycles"}, W'(bc), W'(K));
        checkOutput({tag, ".done"}, W'(busIf.done), W'(1));
        checkOutput({tag, ".busyAtDone"}, W'(busIf.busy), W'(0));
        checkOutput({tag, ".diff"}, busIf.diff, exp[W-1:0]);
        checkOutput({tag, ".bout"}, W'(busIf.bout), W'(exp[W]));
    endtask

    task automatic countDones(input int span, output int n);
        n = 0;
        repeat (span) begin
            @(negedge clk);
            if (busIf.done === 1'b1) n++;
        end
    endtask

    initial begin
        int c;
        int bc;
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rbin;

        busIf.start = 1'b0;
        busIf.a     = '0;
        busIf.b     = '0;
        busIf.bin   = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", W'(busIf.busy), W'(0));
        checkOutput("reset.done", W'(busIf.done), W'(0));
        checkOutput("reset.diff", busIf.diff, W'(0));
        checkOutput("reset.bout", W'(busIf.bout), W'(0));
        rst = 1'b0;
        @(negedge clk);

        runOp("crossLimb", 16'h1000, 16'h0001, 1'b0, 1'b0);
        checkOutput("crossLimb.value", busIf.diff, 16'h0FFF);
        @(negedge clk);
        checkOutput("crossLimb.donePulse", W'(busIf.done), W'(0));
        checkOutput("crossLimb.idleBusy", W'(busIf.busy), W'(0));
        checkOutput("crossLimb.diffHold", busIf.diff, 16'h0FFF);

        runOp("underflow", 16'h0000, 16'h0000, 1'b1, 1'b0);
        checkOutput("underflow.value", busIf.diff, 16'hFFFF);
        @(negedge clk);

        runOp("equal", 16'h1234, 16'h1234, 1'b0, 1'b1);
        checkOutput("equal.value", busIf.diff, 16'h0000);
        @(negedge clk);

        $display("[TB] start while busy");
        applyStimulus(16'h00FF, 16'h0010, 1'b0);
        @(negedge clk);
        busIf.a     = W'($urandom);
        busIf.b     = W'($urandom);
        busIf.bin   = 1'b1;
        busIf.start = 1'b1;
        @(negedge clk);
        busIf.start = 1'b0;
        waitDone(1'b0, c, bc);
        checkOutput("busyStart.latency", W'(c + 2), W'(K));
        checkOutput("busyStart.diff", busIf.diff, 16'h00EF);
        checkOutput("busyStart.bout", W'(busIf.bout), W'(0));
        countDones(10, n);
        checkOutput("busyStart.extraDone", W'(n), W'(0));

        $display("[TB] back-to-back");
        applyStimulus(16'h8000, 16'h0001, 1'b0);
        waitDone(1'b0, c, bc);
        checkOutput("b2b.first.done", W'(busIf.done), W'(1));
        checkOutput("b2b.first.diff", busIf.diff, 16'h7FFF);
        checkOutput("b2b.first.bout", W'(busIf.bout), W'(0));
        applyStimulus(16'h0001, 16'h0002, 1'b0);
        checkOutput("b2b.restartBusy", W'(busIf.busy), W'(1));
        waitDone(1'b0, c, bc);
        checkOutput("b2b.gap", W'(c + 1), W'(K + 1));
        checkOutput("b2b.second.done", W'(busIf.done), W'(1));
        checkOutput("b2b.second.diff", busIf.diff, 16'hFFFF);
        checkOutput("b2b.second.bout", W'(busIf.bout), W'(1));
        @(negedge clk);

        $display("[TB] reset mid-operation");
        applyStimulus(16'hA5C3, 16'h1234, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midReset.busy", W'(busIf.busy), W'(0));
        checkOutput("midReset.done", W'(busIf.done), W'(0));
        checkOutput("midReset.diff", busIf.diff, W'(0));
        checkOutput("midReset.bout", W'(busIf.bout), W'(0));
        countDones(8, n);
        checkOutput("midReset.noDone", W'(n), W'(0));
        runOp("afterReset", 16'h4321, 16'h5678, 1'b0, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            if (i == 0) rb = ra;
            runOp($sformatf("rand%0d", i), ra, rb, rbin, 1'b1);
            if (i % 3 != 2) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/msub_seq.md
# msub_seq

Multi-precision subtract sequencer. It computes `a - b - bin` on `K`-limb operands, each limb `N` bits wide, by time-multiplexing one `N`-bit limb subtractor. It processes one limb per cycle from least significant upward and chains the borrow through a register. It sits in the combinational-circuits library as the reusable controller that lets a narrow subtractor serve wide operands.

## Interface
- Parameters:
  - `N`, 4: limb width in bits; must be ≥1.
  - `K`, 4: number of limbs; must be ≥2. Operand width `W = N*K`.
- Ports:
  - `clk  in  1`: single clock, rising-edge.
  - `rst  in  1`: synchronous, active-high reset.
  - `start  in  1`: request. Sampled only when `busy`=0.
  - `a  in  W`: minuend. Latched on accepted start.
  - `b  in  W`: subtrahend. Latched on accepted start.
  - `bin  in  1`: borrow-in. Latched on accepted start.
  - `busy  out  1`: high while limbs are being processed.
  - `done  out  1`: one-cycle pulse; result valid.
  - `diff  out  W`: result register.
  - `bout  out  1`: final borrow-out. 1 iff `a < b + bin` as unsigned.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE after limb `K-1` is written.
  - DONE → RUN if `start`=1, else DONE → IDLE.
- Accepted start, in IDLE or DONE:
  - latch `a`, `b`;
  - set borrow register to `bin`;
  - set limb index to 0;
  - clear `diff` to 0 and `bout` to 0.
- RUN, limb `i` = index:
  - `{bnext, d} = a[i*N +: N] - b[i*N +: N] - borrow`, evaluated in `N+1` bits.
  - `diff[i*N +: N] <= d`; `borrow <= bnext`; index increments.
  - At `i = K-1`: `bout <= bnext` and go to DONE.
- Index width is `$clog2(K)`, minimum 1. Index never exceeds `K-1`; no wrap occurs.
- Ports `a`, `b`, `bin` may change freely after acceptance. Only the latched copies are used.
- `start` while `busy`=1 is ignored, with no queueing.
- `start` during the DONE cycle is accepted: a back-to-back operation runs with no IDLE cycle.
- `diff` and `bout` hold their values after DONE until the next accepted start.
- Reset, at any time including mid-RUN:
  - state IDLE, index 0, borrow 0;
  - `busy`=0, `done`=0, `diff`=0, `bout`=0;
  - the operation in progress is abandoned, and no `done` is produced.

## Timing
- Accepted start at edge E0:
  - `busy`=1 from E0 through E(K).
  - Limb `i` is written at edge E(i+1).
  - `busy`=0 and `done`=1 for exactly the cycle after E(K).
- Latency: `K` cycles from start edge to `done`. Throughput: one operation per `K+1` cycles, back-to-back.
- All outputs are registered, with no combinational path from inputs to outputs.
- `done` and `busy` are never high together.

## Structure
- Package `msub_pkg`: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2). Unused code 2'd3 returns to IDLE.
- Sub-module `limb_sub`, parameter `N`:
  - purely combinational;
  - ports `x[N-1:0]`, `y[N-1:0]`, `bi`, `d[N-1:0]`, `bo`;
  - instantiated once in `msub_seq`.
- `msub_seq` holds the FSM, index counter, borrow register, operand latches and result register.

## Test plan
All scenarios use N=4, K=4.
- Cross-limb borrow: `a`=16'h1000, `b`=16'h0001, `bin`=0, start for 1 cycle → `done` 4 cycles later, `diff`=16'h0FFF, `bout`=0; `busy` high for exactly 4 cycles.
- Full underflow: `a`=16'h0000, `b`=16'h0000, `bin`=1 → `diff`=16'hFFFF, `bout`=1.
- Equal operands: `a`=`b`=16'h1234, `bin`=0 → `diff`=16'h0000, `bout`=0. Operand ports are changed to random values during RUN, and the result is unaffected.
- Start while busy:
  - first op `a`=16'h00FF, `b`=16'h0010;
  - second start pulse at cycle 2 with other operands → ignored;
  - only one `done`, `diff`=16'h00EF.
- Back-to-back:
  - first op `a`=16'h8000, `b`=16'h0001, `bin`=0 → 16'h7FFF;
  - second start in the DONE cycle with `a`=16'h0001, `b`=16'h0002, `bin`=0 → 16'hFFFF, `bout`=1;
  - second `done` exactly 5 cycles after the first.
- Reset mid-op:
  - `rst` asserted at cycle 2 of RUN → next cycle `busy`=0, `diff`=0, `bout`=0, and no `done`;
  - a new start afterwards completes correctly.
